mem2p_fifo_ctrl: RTL and testbench

//  Initiator-side controller for the two-port memory mem2p11_dxw_p: drives its write port
//  (addrw/din/mew) and read port (addrr/mer), and captures dout.

---
 rtl/mem2p_fifo_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem2p_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2p_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem2p_fifo_ctrl
// Purpose  : Streaming valid/ready FIFO built on an external two-port memory
//            (mem2p11_dxw_p). First-word-fall-through output is provided by a
//            2-entry output buffer that absorbs the 1-cycle read latency.
// Options  : MEM2P_FIFO_LEVEL_EN adds registered level_o / afull_o outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mem2p_fifo_ctrl #(
  parameter int DEPTH    = 2048,
  parameter int WIDTH    = 24,
  parameter int A        = $clog2(DEPTH),
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // upstream
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  // downstream
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  // memory write port
  output logic [A-1:0]     addrw_o,
  output logic [WIDTH-1:0] din_o,
  output logic             mew_o,
  // memory read port
  output logic [A-1:0]     addrr_o,
  output logic             mer_o,
  input  logic [WIDTH-1:0] dout_i
`ifdef MEM2P_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+3)-1:0] level_o,
  output logic                       afull_o
`endif
);

  localparam logic [A:0] C_CNT_FULL = (A+1)'(DEPTH);

  // Registered state
  logic [A-1:0]     wptr_q, wptr_d;
  logic [A-1:0]     rptr_q, rptr_d;
  logic [A:0]       mem_cnt_q, mem_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       ob_cnt_q, ob_cnt_d;
  logic [WIDTH-1:0] ob0_q, ob0_d;
  logic [WIDTH-1:0] ob1_q, ob1_d;

  // Handshake terms
  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] ob_occ;
  logic [1:0] ob_slot;

  // s_ready depends only on registered state, so no combinational path from s_valid
  assign s_ready_o = (mem_cnt_q != C_CNT_FULL);
  assign m_valid_o = (ob_cnt_q != 2'd0);
  assign m_data_o  = ob0_q;

  assign push = s_valid_i & s_ready_o;
  assign pop  = m_valid_o & m_ready_i;

  // Occupancy the output buffer will have once the pending read lands and the pop leaves;
  // a new read is only issued if there is room for it one cycle later.
  assign ob_occ = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (mem_cnt_q != '0) && (ob_occ <= 3'd1);

  // Slot that returning read data lands in, after any shift due to pop
  assign ob_slot = ob_cnt_q - {1'b0, pop};

  assign mew_o   = push;
  assign addrw_o = wptr_q;
  assign din_o   = s_data_i;
  assign mer_o   = issue;
  assign addrr_o = rptr_q;

  // Next-state computation for pointers, counters and output buffer
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_cnt_d  = mem_cnt_q;
    inflight_d = issue;
    ob_cnt_d   = ob_cnt_q;
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;

    // DEPTH is a power of two, so natural pointer overflow gives the wrap
    if (push)  wptr_d = wptr_q + 1'b1;
    if (issue) rptr_d = rptr_q + 1'b1;

    mem_cnt_d = mem_cnt_q + (A+1)'(push) - (A+1)'(issue);
    ob_cnt_d  = ob_cnt_q - {1'b0, pop} + {1'b0, inflight_q};

    if (pop) ob0_d = ob1_q;
    if (inflight_q) begin
      if (ob_slot == 2'd0) ob0_d = dout_i;
      else                 ob1_d = dout_i;
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      ob0_q      <= '0;
      ob1_q      <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
    end
  end

`ifdef MEM2P_FIFO_LEVEL_EN
  localparam int LW = $clog2(DEPTH+3);
  localparam logic [LW-1:0] C_AFULL = LW'(AFULL_TH);

  logic [LW-1:0] level_q, level_d;
  logic          afull_q, afull_d;

  // Level is built from next-state terms so the registered value tracks current occupancy
  always_comb begin
    level_d = LW'(mem_cnt_d) + LW'(inflight_d) + LW'(ob_cnt_d);
    afull_d = (level_d >= C_AFULL);
  end

  // Level / almost-full registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign level_o = level_q;
  assign afull_o = afull_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem2p_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem2p_fifo_ctrl
// Purpose  : Directed self-checking bench for mem2p_fifo_ctrl with a
//            behavioural two-port memory (1-cycle registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem2p_fifo_ctrl;

  localparam int DEPTH = 2048;
  localparam int WIDTH = 24;
  localparam int A     = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready, m_valid, m_ready, mew, mer;
  logic [WIDTH-1:0] s_data, m_data, din, dout;
  logic [A-1:0]     addrw, addrr;
`ifdef MEM2P_FIFO_LEVEL_EN
  logic [$clog2(DEPTH+3)-1:0] level;
  logic                       afull;
`endif

  always #5 clk = ~clk;

  mem2p_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .s_data_i  (s_data),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .addrw_o   (addrw),
    .din_o     (din),
    .mew_o     (mew),
    .addrr_o   (addrr),
    .mer_o     (mer),
    .dout_i    (dout)
`ifdef MEM2P_FIFO_LEVEL_EN
    ,
    .level_o   (level),
    .afull_o   (afull)
`endif
  );

  // Behavioural mem2p11_dxw_p: synchronous write, registered read
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (mew) mem[addrw] <= din;
    if (mer) dout <= mem[addrr];
  end

  int n_chk = 0, n_pass = 0;
  int tot_push = 0, tot_pop = 0, gaps = 0;
  int p0, q0;
  bit streaming = 0, started = 0, hold_v = 0, pushed;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] dval, last_pop, hold_d, exp_d;
  logic [A-1:0]     wa_exp = '0, ra_exp = '0;
  logic [WIDTH-1:0] t2_exp [0:2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // One clock: sample at negedge (scoreboard, stability, address wrap), then step past posedge
  task automatic tick();
    @(negedge clk);
    if (hold_v) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(hold_d));
    end
    if (mew) begin
      if (wa_exp == 11'd2047 || wa_exp == 11'd0) check("addrw_wrap", 32'(addrw), 32'(wa_exp));
      wa_exp = wa_exp + 1'b1;
    end
    if (mer) begin
      if (ra_exp == 11'd2047 || ra_exp == 11'd0) check("addrr_wrap", 32'(addrr), 32'(ra_exp));
      ra_exp = ra_exp + 1'b1;
    end
    pushed = s_valid && s_ready;
    if (pushed) begin
      sb.push_back(s_data);
      tot_push++;
    end
    if (m_valid && m_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_d = sb.pop_front();
        check("pop_data", 32'(m_data), 32'(exp_d));
      end
      last_pop = m_data;
      tot_pop++;
      started = 1;
    end else if (streaming && started) begin
      gaps++;
    end
    hold_v = m_valid && !m_ready;
    hold_d = m_data;
    @(posedge clk);
    #1;
    if (pushed) begin
      dval   = dval + 1'b1;
      s_data = dval;
    end
  endtask

  initial begin
    t2_exp[0] = 24'habcdef;
    t2_exp[1] = 24'habcdf0;
    t2_exp[2] = 24'habcdf1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    dval    = '0;
    s_data  = '0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_mew",     32'(mew),     32'd0);
    check("rst_mer",     32'(mer),     32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_addrw",   32'(addrw),   32'd0);
    check("rst_addrr",   32'(addrr),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: three pushes, downstream stalled
    dval = 24'habcdef; s_data = dval; s_valid = 1'b1;
    tick();
    check("t1_mvalid_e0", 32'(m_valid), 32'd0);
    check("t1_mer_e0",    32'(mer),     32'd1);
    check("t1_addrr_e0",  32'(addrr),   32'd0);
    tick();
    check("t1_mvalid_e1", 32'(m_valid), 32'd0);
    tick();
    s_valid = 1'b0;
    check("t1_mvalid_e2", 32'(m_valid), 32'd1);
    check("t1_mdata_e2",  32'(m_data),  32'h00abcdef);
    repeat (3) tick();
    check("t1_mdata_held", 32'(m_data), 32'h00abcdef);

    // 2: drain, one word per cycle
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_mvalid", 32'(m_valid), 32'd1);
      check("t2_mdata",  32'(m_data),  32'(t2_exp[i]));
      tick();
    end
    check("t2_empty", 32'(m_valid), 32'd0);

    // 3: sustained streaming of 5000 words
    dval = '0; s_data = dval; s_valid = 1'b1; m_ready = 1'b1;
    p0 = tot_push; streaming = 1; started = 0; gaps = 0;
    for (int i = 0; i < 6000; i++) begin
      if (tot_push - p0 == 5000) break;
      tick();
    end
    s_valid = 1'b0; streaming = 0;
    check("t3_pushed", 32'(tot_push - p0), 32'd5000);
    check("t3_gaps",   32'(gaps),          32'd0);
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0 && !m_valid) break;
      tick();
    end
    check("t3_drained", 32'(sb.size()), 32'd0);

    // 4: fill to capacity with downstream stalled
    m_ready = 1'b0; s_valid = 1'b1; p0 = tot_push;
    for (int i = 0; i < 2100; i++) begin
      if (!s_ready) break;
      tick();
`ifdef MEM2P_FIFO_LEVEL_EN
      if (tot_push - p0 == 2043) check("t4_afull_2043", 32'(afull), 32'd0);
      if (tot_push - p0 == 2044) check("t4_afull_2044", 32'(afull), 32'd1);
`endif
    end
    check("t4_accepted", 32'(tot_push - p0), 32'd2050);
    check("t4_full",     32'(s_ready),       32'd0);
`ifdef MEM2P_FIFO_LEVEL_EN
    check("t4_level", 32'(level), 32'd2050);
    check("t4_afull", 32'(afull), 32'd1);
`endif
    s_valid = 1'b0; m_ready = 1'b1; q0 = tot_pop;
    tick();
    m_ready = 1'b0;
    check("t4_pop",        32'(tot_pop - q0), 32'd1);
    check("t4_sready_up",  32'(s_ready),      32'd1);
    s_valid = 1'b1; p0 = tot_push;
    tick();
    check("t4_refill",     32'(tot_push - p0), 32'd1);
    check("t4_full_again", 32'(s_ready),       32'd0);

    // 5: full, push and pop offered together
    m_ready = 1'b1; p0 = tot_push; q0 = tot_pop;
    check("t5_sready_low", 32'(s_ready), 32'd0);
    tick();
    m_ready = 1'b0;
    check("t5_pop_done",   32'(tot_pop - q0),  32'd1);
    check("t5_push_refd",  32'(tot_push - p0), 32'd0);
    check("t5_sready_up",  32'(s_ready),       32'd1);
    tick();
    check("t5_push_next",  32'(tot_push - p0), 32'd1);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 2200; i++) begin
      if (sb.size() == 0 && !m_valid) break;
      tick();
    end
    check("t5_drained", 32'(sb.size()),  32'd0);
    check("t5_mvalid",  32'(m_valid),    32'd0);

    // 6: asynchronous reset in the middle of a stream
    s_valid = 1'b1; m_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0; s_valid = 1'b0;
    #1;
    check("t6_m_valid", 32'(m_valid), 32'd0);
    check("t6_mew",     32'(mew),     32'd0);
    check("t6_mer",     32'(mer),     32'd0);
    check("t6_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete(); hold_v = 0; wa_exp = '0; ra_exp = '0;
    dval = 24'h00ffff; s_data = dval; s_valid = 1'b1; m_ready = 1'b1; q0 = tot_pop;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tot_pop != q0) break;
      tick();
    end
    check("t6_popped", 32'(tot_pop - q0), 32'd1);
    check("t6_first",  32'(last_pop),     32'h0000ffff);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
